// File: rtl/fetch_unit_pkg.sv
// Shared CPU types and constants used by the fetch stage.
package fetch_unit_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH,
        KILL,
        HOLD
    } fetch_state_t;

    localparam word_t NOP_INSTR    = 32'h0000_0000;
    localparam word_t RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_ifid_reg.sv
// IF/ID pipeline register: clear beats load, load beats hold.
module ifid_reg
    import fetch_unit_pkg::*;
#(
    parameter word_t NOP = NOP_INSTR
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clear,
    input  logic  load,
    input  logic  bubble,
    input  word_t load_instr,
    input  word_t load_pc,
    output logic  valid,
    output word_t instr,
    output word_t pc,
    output word_t pc4
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= NOP;
            pc    <= '0;
            pc4   <= 32'd4;
        end else if (clear || bubble) begin
            valid <= 1'b0;
            instr <= NOP;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
            pc4   <= load_pc + 32'd4;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, redirect handling, req/ack memory port,
// one-entry skid buffer and the IF/ID register.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEF,
    parameter word_t NOP      = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4
);

    fetch_state_t state, state_n;
    word_t pc, pc_n, pend, pend_n;
    word_t skid_instr, skid_pc;
    logic  skid_we;
    logic  req_q;

    logic  redirect, ack;
    word_t target, pc_inc;

    logic  ld_clear, ld_load, ld_bubble;
    word_t ld_instr, ld_pc;

    // Branch resolves in EX, so it is older than a jump in ID.
    assign redirect = br_taken | jmp;
    assign target   = (br_taken ? br_target : jmp_target) & ~32'd3;
    assign ack      = imem_ack & req_q;
    assign pc_inc   = pc + 32'd4;

    assign imem_req  = req_q;
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            pend       <= RESET_PC;
            skid_instr <= NOP;
            skid_pc    <= '0;
            req_q      <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            pend  <= pend_n;
            req_q <= (state_n != HOLD);
            if (skid_we) begin
                skid_instr <= imem_rdata;
                skid_pc    <= pc;
            end
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        pend_n  = pend;
        skid_we = 1'b0;
        unique case (state)
            FETCH: begin
                if (redirect) begin
                    // An unacked access must drain before the target goes out.
                    if (ack || !req_q) begin
                        pc_n = target;
                    end else begin
                        pend_n  = target;
                        state_n = KILL;
                    end
                end else if (ack) begin
                    pc_n = pc_inc;
                    if (stall && ifid_valid) begin
                        skid_we = 1'b1;
                        state_n = HOLD;
                    end
                end
            end
            KILL: begin
                if (redirect) pend_n = target;
                if (ack) begin
                    pc_n    = redirect ? target : pend;
                    state_n = FETCH;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_n    = target;
                    state_n = FETCH;
                end else if (!stall) begin
                    state_n = FETCH;
                end
            end
            default: state_n = FETCH;
        endcase
    end

    always_comb begin
        ld_clear  = redirect;
        ld_load   = 1'b0;
        ld_bubble = 1'b0;
        ld_instr  = imem_rdata;
        ld_pc     = pc;
        unique case (state)
            FETCH: begin
                if (ack && !(stall && ifid_valid)) begin
                    ld_load = 1'b1;
                end else if (!ack && !stall) begin
                    ld_bubble = 1'b1;
                end
            end
            HOLD: begin
                if (!stall) begin
                    ld_load  = 1'b1;
                    ld_instr = skid_instr;
                    ld_pc    = skid_pc;
                end
            end
            default: ;
        endcase
    end

    ifid_reg #(
        .NOP(NOP)
    ) u_ifid (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (ld_clear),
        .load      (ld_load),
        .bubble    (ld_bubble),
        .load_instr(ld_instr),
        .load_pc   (ld_pc),
        .valid     (ifid_valid),
        .instr     (ifid_instr),
        .pc        (ifid_pc),
        .pc4       (ifid_pc4)
    );

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined processor. It owns the fetch program counter, computes the next PC (sequential +4, branch target, or jump target), and drives a req/ack instruction-memory port. Returned instructions go into the IF/ID pipeline register for the decode stage. It handles decode stalls with a one-entry skid buffer and handles redirects that occur while a memory access is still outstanding.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset
- NOP, 32'h0000_0000, instruction value placed in IF/ID when it is invalid

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- stall  in  1  decode cannot accept; IF/ID must hold
- br_taken  in  1  branch resolved taken (EX stage)
- br_target  in  32  branch target
- jmp  in  1  jump decoded (ID stage)
- jmp_target  in  32  jump target
- imem_req  out  1  instruction-memory request
- imem_addr  out  32  request address; stable while imem_req=1 and imem_ack=0
- imem_ack  in  1  access complete; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- ifid_valid  out  1  IF/ID holds a live instruction
- ifid_instr  out  32  instruction to decode
- ifid_pc  out  32  address of ifid_instr
- ifid_pc4  out  32  ifid_pc + 4

## Operation
- pc register = address of the next fetch. imem_addr = pc in FETCH; imem_addr = pc in KILL.
- Redirect:
  - redirect = br_taken | jmp.
  - Target = br_target if br_taken, else jmp_target; br_taken has priority (older instruction).
  - Target bits [1:0] are forced to 00.
- Redirect has priority over stall. In every state, a redirect clears ifid_valid to 0, sets ifid_instr to NOP, and empties the skid buffer.
- All PC arithmetic is modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0.
- A cycle that "accepts" the returned word captures {rdata, pc} into IF/ID and sets ifid_valid=1.
- States:
  - FETCH (imem_req=1):
    - ack & redirect: discard rdata; pc<=target; stay in FETCH.
    - ack & !redirect & (!stall | !ifid_valid): accept; pc<=pc+4.
    - ack & !redirect & stall & ifid_valid: write rdata and pc into the skid buffer; pc<=pc+4; go to HOLD.
    - !ack & redirect: pend<=target; go to KILL.
    - !ack & !redirect & !stall: ifid_valid<=0 (bubble).
  - KILL (imem_req=1, address unchanged):
    - A redirect updates pend; the newest redirect wins.
    - ack: discard rdata; pc<=pend; go to FETCH.
  - HOLD (imem_req=0):
    - redirect: pc<=target; go to FETCH.
    - !stall: move the skid buffer into IF/ID; go to FETCH.
    - stall: hold everything.
- imem_ack while imem_req=0 is ignored.
- When stall=1 and there is no redirect, the IF/ID outputs are unchanged.

## Timing
- While rst_n=0 at a clock edge, the next state is:
  - pc = RESET_PC, state = FETCH, skid buffer empty
  - imem_req = 0
  - ifid_valid = 0, ifid_instr = NOP, ifid_pc = 0, ifid_pc4 = 4
- First cycle after reset release: imem_req=1, imem_addr=RESET_PC.
- imem_req is a registered qualifier: it is 0 in the reset cycle and 1 in FETCH/KILL.
- Latency: ack in cycle N gives ifid_valid=1 with that word in cycle N+1, and imem_addr=pc+4 in cycle N+1.
- With zero-wait memory (ack every cycle), throughput is 1 instruction/cycle.
- A redirect asserted in cycle N:
  - IF/ID is invalid in N+1.
  - The target is presented in N+1 if there is no outstanding access; otherwise in the cycle after the outstanding ack.
- Asserting reset mid-access (any state) abandons the access. The outstanding ack after reset is not expected; if one arrives in the first FETCH cycle, it is treated as the ack for RESET_PC.

## Structure
- The shared CPU package holds:
  - the fetch state enum {FETCH, KILL, HOLD}
  - the NOP constant
  - the RESET_PC default
  - a 32-bit word typedef
- One sub-module, ifid_reg: the IF/ID register with hold (stall), clear (redirect), and load.
- FSM, pc, pend and the skid buffer stay in fetch_unit.

## Test plan
- Reset then ack every cycle, memory returns addr as data:
  - imem_addr sequence 0, 4, 8, 12.
  - ifid_instr/ifid_pc follow one cycle later; ifid_pc4 = ifid_pc+4.
- Ack every cycle; stall=1 for 3 cycles while ifid_pc=8:
  - IF/ID holds 8 for the whole stall.
  - Word 12 goes to the skid buffer; imem_req=0 during HOLD.
  - After stall drops: IF/ID shows 12, then fetch resumes at 16.
  - Nothing lost or duplicated.
- 3-wait-state memory; br_taken with br_target=0x100 in the first wait cycle:
  - imem_addr stays unchanged until ack; that word is discarded.
  - Next imem_addr = 0x100; ifid_valid=0 until the 0x100 word returns.
- br_taken (target 0x200) and jmp (target 0x300) in the same cycle, during a stall:
  - IF/ID is cleared despite the stall.
  - Next fetch is at 0x200.
- Start at RESET_PC=32'hFFFF_FFF8 with ack every cycle:
  - Fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - jmp_target 0x103 is fetched as 0x100.
- Deassert rst_n in KILL with an outstanding access:
  - Next cycle: imem_req=0, ifid_valid=0.
  - After release: fetch restarts at RESET_PC.
